tile_target_sequencer: RTL

Downstream consumer of the 3-bit pseudo-random tile generator in the tile-flip game. On a start pulse it samples the random stream and fills a sequence buffer of target tiles. It then plays the sequence out one tile at a time as a timed one-hot "flip" pattern for the display logic. Afterwards it holds the sequence in a read port for the player-input comparison stage.

---
 rtl/tile_target_sequencer_if.sv | 25 ++
 rtl/tile_target_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tile_target_sequencer_if.sv
// Bus between the tile target sequencer and its neighbours: round control,
// random tile input, the one-hot flip pattern and the sequence read port.
interface tile_target_sequencer_if;
  logic       start;
  logic [2:0] random_num;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] tile_mask;
  logic [2:0] show_idx;
  logic [2:0] rd_idx;
  logic [2:0] rd_tile;

  // Game controller / consumer side
  modport master (
    output start, random_num, rd_idx,
    input  busy, done, error, tile_mask, show_idx, rd_tile
  );

  // Sequencer side
  modport slave (
    input  start, random_num, rd_idx,
    output busy, done, error, tile_mask, show_idx, rd_tile
  );
endinterface

// File: rtl/tile_target_sequencer.sv
// Tile target sequencer for the tile-flip game.
// Collects SEQ_LEN target tiles from the random stream, plays them out as a
// timed one-hot flip pattern, then holds them on a registered read port.
// Optional macro UNIQUE_TILES_EN: reject tiles already taken this round so
// every target in a round is distinct (SEQ_LEN must then be <= 7).
module tile_target_sequencer #(
  parameter int SEQ_LEN       = 4,
  parameter int SHOW_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 12500000,
  parameter int COLLECT_LIMIT = 64
) (
  input logic                    clk,
  input logic                    reset,
  tile_target_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SHOW    = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // One shared timer serves as the collect-cycle counter and the show/gap
  // timer, so it is sized for the largest of the three limits.
  localparam int MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_SG > COLLECT_LIMIT) ? MAX_SG : COLLECT_LIMIT;
  localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] COLLECT_LAST = TW'(COLLECT_LIMIT - 1);
  localparam logic [3:0]    SEQ_LAST     = 4'(SEQ_LEN - 1);
  localparam logic [3:0]    SEQ_SIZE     = 4'(SEQ_LEN);

  logic [2:0]    r_state;
  logic [2:0]    r_buffer [0:7];
  logic [3:0]    r_wrPtr;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_showIdx;
  logic          r_error;
  logic [2:0]    r_rdTile;
  logic          w_accept;
  logic          w_lastWrite;

`ifdef UNIQUE_TILES_EN
  logic [7:0]    r_usedMask;

  assign w_accept = ~r_usedMask[bus.random_num];

  // Track which tiles are already taken in the current round
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_usedMask <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && bus.start) begin
      r_usedMask <= '0;
    end else if (r_state == S_COLLECT && w_accept) begin
      r_usedMask[bus.random_num] <= 1'b1;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  assign w_lastWrite = w_accept && (r_wrPtr == SEQ_LAST);

  // Round state machine: collect targets, play them out, then hold them
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wrPtr   <= '0;
      r_timer   <= '0;
      r_showIdx <= '0;
      r_error   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_buffer[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_wrPtr <= '0;
            r_timer <= '0;
            r_error <= 1'b0;
            r_state <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (w_accept) begin
            r_buffer[r_wrPtr[2:0]] <= bus.random_num;
            r_wrPtr                <= r_wrPtr + 4'd1;
          end
          if (w_lastWrite) begin
            r_state   <= S_SHOW;
            r_showIdx <= '0;
            r_timer   <= '0;
          end else if (r_timer == COLLECT_LAST) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_SHOW: begin
          if (r_timer == SHOW_LAST) begin
            r_timer <= '0;
            if ({1'b0, r_showIdx} == SEQ_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_showIdx <= r_showIdx + 3'd1;
              r_state   <= (GAP_CYCLES == 0) ? S_SHOW : S_GAP;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            r_state <= S_SHOW;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered read port; addresses past the sequence length read as zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdTile <= '0;
    end else if ({1'b0, bus.rd_idx} < SEQ_SIZE) begin
      r_rdTile <= r_buffer[bus.rd_idx];
    end else begin
      r_rdTile <= '0;
    end
  end

  // Status and flip pattern decoded from the registered state
  always_comb begin
    bus.busy      = (r_state == S_COLLECT) || (r_state == S_SHOW) || (r_state == S_GAP);
    bus.done      = (r_state == S_DONE);
    bus.error     = r_error;
    bus.show_idx  = r_showIdx;
    bus.rd_tile   = r_rdTile;
    bus.tile_mask = '0;
    if (r_state == S_SHOW) begin
      bus.tile_mask = 8'd1 << r_buffer[r_showIdx];
    end
  end

endmodule
